// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter sharing the MIG 7-series app interface between PSC, DSC and L2.
// One single-beat read or write per grant; read data is routed back to the owning requester.
module ddr_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    clk_166M66,
  input  logic                    mcu_sys_rst,
  input  logic                    i_init_calib_complete,
  input  logic                    i_psc_request,
  input  logic                    i_psc_rw,
  input  logic [ADDR_WIDTH-1:0]   i_psc_addr,
  input  logic [DATA_WIDTH-1:0]   i_psc_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_psc_wmask,
  output logic                    o_psc_grant,
  output logic                    o_psc_done,
  input  logic                    i_dsc_request,
  input  logic                    i_dsc_rw,
  input  logic [ADDR_WIDTH-1:0]   i_dsc_addr,
  input  logic [DATA_WIDTH-1:0]   i_dsc_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_dsc_wmask,
  output logic                    o_dsc_grant,
  output logic                    o_dsc_done,
  input  logic                    i_l2_request,
  input  logic                    i_l2_rw,
  input  logic [ADDR_WIDTH-1:0]   i_l2_addr,
  input  logic [DATA_WIDTH-1:0]   i_l2_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_l2_wmask,
  output logic                    o_l2_grant,
  output logic                    o_l2_done,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_err,
  output logic [ADDR_WIDTH-1:0]   o_app_addr,
  output logic [2:0]              o_app_cmd,
  output logic                    o_app_en,
  input  logic                    i_app_rdy,
  output logic [DATA_WIDTH-1:0]   o_app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] o_app_wdf_mask,
  output logic                    o_app_wdf_wren,
  output logic                    o_app_wdf_end,
  input  logic                    i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   i_app_rd_data,
  input  logic                    i_app_rd_data_valid
);

  localparam int         MW     = DATA_WIDTH / 8;
  localparam logic [7:0] TO_LIM = 8'(RD_TIMEOUT);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_e;

  state_e                state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [1:0]            last_q, last_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  en_q, en_d, wren_q, wren_d;
  logic                  cmd_ok_q, cmd_ok_d, dat_ok_q, dat_ok_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [MW-1:0]         mask_q, mask_d;

  logic [2:0]            req, rw;
  logic [ADDR_WIDTH-1:0] req_addr  [3];
  logic [DATA_WIDTH-1:0] req_wdata [3];
  logic [MW-1:0]         req_mask  [3];
  logic [1:0]            win;

  assign req = {i_l2_request, i_dsc_request, i_psc_request};
  assign rw  = {i_l2_rw, i_dsc_rw, i_psc_rw};
  assign req_addr[0]  = i_psc_addr;
  assign req_addr[1]  = i_dsc_addr;
  assign req_addr[2]  = i_l2_addr;
  assign req_wdata[0] = i_psc_wdata;
  assign req_wdata[1] = i_dsc_wdata;
  assign req_wdata[2] = i_l2_wdata;
  assign req_mask[0]  = i_psc_wmask;
  assign req_mask[1]  = i_dsc_wmask;
  assign req_mask[2]  = i_l2_wmask;

  // Search order starts just after the last granted requester.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c0, c1, c2;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (r[c0]) return c0;
    if (r[c1]) return c1;
    return c2;
  endfunction

  assign win = rr_pick(req, last_q);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    en_d     = en_q;
    wren_d   = wren_q;
    cmd_ok_d = cmd_ok_q;
    dat_ok_d = dat_ok_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE; grant drops here and arbitration waits a cycle.
        if (done_q) begin
          grant_d = '0;
        end else if (i_init_calib_complete && |req) begin
          grant_d  = 3'b001 << win;
          last_d   = win;
          addr_d   = req_addr[win];
          wdata_d  = req_wdata[win];
          mask_d   = req_mask[win];
          cmd_d    = rw[win] ? CMD_WR : CMD_RD;
          en_d     = 1'b1;
          wren_d   = rw[win];
          cmd_ok_d = 1'b0;
          dat_ok_d = 1'b0;
          state_d  = rw[win] ? WR : RD_CMD;
        end
      end
      WR: begin
        en_d     = en_q & ~i_app_rdy;
        wren_d   = wren_q & ~i_app_wdf_rdy;
        cmd_ok_d = cmd_ok_q | (en_q & i_app_rdy);
        dat_ok_d = dat_ok_q | (wren_q & i_app_wdf_rdy);
        if (cmd_ok_d && dat_ok_d) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_CMD: begin
        if (i_app_rdy) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (i_app_rd_data_valid) begin
          rdata_d = i_app_rd_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q + 8'd1 == TO_LIM) begin
          rdata_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (mcu_sys_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 2'd2;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      wren_q   <= 1'b0;
      cmd_ok_q <= 1'b0;
      dat_ok_q <= 1'b0;
      cnt_q    <= '0;
      cmd_q    <= CMD_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      en_q     <= en_d;
      wren_q   <= wren_d;
      cmd_ok_q <= cmd_ok_d;
      dat_ok_q <= dat_ok_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_psc_grant    = grant_q[0];
  assign o_dsc_grant    = grant_q[1];
  assign o_l2_grant     = grant_q[2];
  assign o_psc_done     = done_q & grant_q[0];
  assign o_dsc_done     = done_q & grant_q[1];
  assign o_l2_done      = done_q & grant_q[2];
  assign o_rd_data      = rdata_q;
  assign o_rd_err       = err_q;
  assign o_app_addr     = addr_q;
  assign o_app_cmd      = cmd_q;
  assign o_app_en       = en_q;
  assign o_app_wdf_data = wdata_q;
  assign o_app_wdf_mask = mask_q;
  assign o_app_wdf_wren = wren_q;
  assign o_app_wdf_end  = wren_q;

endmodule
